call_scheduler: RTL and testbench

CALL_SCHEDULER -- requirements
Module: call_scheduler

---
 rtl/call_scheduler_if.sv | 23 ++
 rtl/call_scheduler.sv | 165 ++++++++++++++++
 tb/tb_call_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/call_scheduler_if.sv
// Signal bundle between the call scheduler and its environment (buttons + movement datapath).
// The scheduler uses the slave view; the stimulus/datapath side uses the master view.
interface call_scheduler_if;
  logic [2:0] call_btn;
  logic       arrived;
  logic       move_req;
  logic [1:0] target;
  logic       dir_up;
  logic       door_open;
  logic       busy;
  logic [2:0] pending;
  logic [1:0] pos;

  modport master (
    output call_btn, arrived,
    input  move_req, target, dir_up, door_open, busy, pending, pos
  );

  modport slave (
    input  call_btn, arrived,
    output move_req, target, dir_up, door_open, busy, pending, pos
  );
endinterface

// File: rtl/call_scheduler.sv
// Three-floor elevator call scheduler: latches calls, picks targets with a sweep policy,
// requests travel from the movement datapath and times the door dwell.
module call_scheduler #(
  parameter int unsigned DOOR_TICKS = 4
) (
  input logic              clk,
  input logic              rst,
  call_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic [7:0] DWELL = 8'(DOOR_TICKS);

  state_t     r_state, w_state;
  logic [2:0] r_pending, w_pending;
  logic [1:0] r_pos, w_pos;
  logic [1:0] r_target, w_target;
  logic       r_dir_up, w_dir_up;
  logic       r_door_open, w_door_open;
  logic       r_move_req, w_move_req;
  logic       r_busy;
  logic [7:0] r_cnt, w_cnt;
  logic [2:0] w_here;
  logic [2:0] w_up_pick;
  logic [2:0] w_dn_pick;

  // Returns {found, floor} for the lowest pending floor strictly above f.
  function automatic logic [2:0] nearest_above(input logic [2:0] p, input logic [1:0] f);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 1; i--) begin
      if (i > int'(f) && p[i-1]) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  // Returns {found, floor} for the highest pending floor strictly below f.
  function automatic logic [2:0] nearest_below(input logic [2:0] p, input logic [1:0] f);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      if (i < int'(f) && p[i-1]) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  // Next-state, target selection and dwell timing.
  always_comb begin
    w_state     = r_state;
    w_pending   = r_pending;
    w_pos       = r_pos;
    w_target    = r_target;
    w_dir_up    = r_dir_up;
    w_door_open = r_door_open;
    w_move_req  = 1'b0;
    w_cnt       = r_cnt;
    w_here      = 3'b001 << (r_pos - 2'd1);
    w_up_pick   = nearest_above(r_pending, r_pos);
    w_dn_pick   = nearest_below(r_pending, r_pos);

    case (r_state)
      IDLE: begin
        w_pending = r_pending | (bus.call_btn & ~w_here);
        if ((bus.call_btn & w_here) != 3'b000) begin
          w_state     = DOOR;
          w_door_open = 1'b1;
          w_cnt       = DWELL;
        end else if (r_dir_up && w_up_pick[2]) begin
          w_target   = w_up_pick[1:0];
          w_move_req = 1'b1;
          w_state    = MOVE;
        end else if (!r_dir_up && w_dn_pick[2]) begin
          w_target   = w_dn_pick[1:0];
          w_move_req = 1'b1;
          w_state    = MOVE;
        end else if (w_up_pick[2]) begin
          // Nothing left in the current sweep direction: reverse.
          w_target   = w_up_pick[1:0];
          w_dir_up   = 1'b1;
          w_move_req = 1'b1;
          w_state    = MOVE;
        end else if (w_dn_pick[2]) begin
          w_target   = w_dn_pick[1:0];
          w_dir_up   = 1'b0;
          w_move_req = 1'b1;
          w_state    = MOVE;
        end else begin
          w_state = IDLE;
        end
      end
      MOVE: begin
        w_pending = r_pending | bus.call_btn;
        if (bus.arrived) begin
          w_pos       = r_target;
          w_pending   = (r_pending | bus.call_btn) & ~(3'b001 << (r_target - 2'd1));
          w_door_open = 1'b1;
          w_cnt       = DWELL;
          w_state     = DOOR;
        end else begin
          w_state = MOVE;
        end
      end
      DOOR: begin
        w_pending = r_pending | (bus.call_btn & ~w_here);
        if ((bus.call_btn & w_here) != 3'b000) begin
          w_cnt = DWELL;
        end else if (r_cnt <= 8'd1) begin
          w_cnt       = 8'd0;
          w_door_open = 1'b0;
          w_state     = IDLE;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state     = IDLE;
        w_door_open = 1'b0;
        w_cnt       = 8'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= 3'b000;
      r_pos       <= 2'd1;
      r_target    <= 2'd1;
      r_dir_up    <= 1'b1;
      r_door_open <= 1'b0;
      r_move_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_state     <= w_state;
      r_pending   <= w_pending;
      r_pos       <= w_pos;
      r_target    <= w_target;
      r_dir_up    <= w_dir_up;
      r_door_open <= w_door_open;
      r_move_req  <= w_move_req;
      r_busy      <= (w_state != IDLE);
      r_cnt       <= w_cnt;
    end
  end

  assign bus.move_req  = r_move_req;
  assign bus.target    = r_target;
  assign bus.dir_up    = r_dir_up;
  assign bus.door_open = r_door_open;
  assign bus.busy      = r_busy;
  assign bus.pending   = r_pending;
  assign bus.pos       = r_pos;

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: directed scenarios plus random calls and a simulated datapath,
// all checked every cycle against a floor/distance based reference model.
module tb_call_scheduler;

  localparam int TICKS = 4;
  localparam int M_WAIT   = 0;
  localparam int M_TRAVEL = 1;
  localparam int M_DWELL  = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  call_scheduler_if bus ();

  call_scheduler #(.DOOR_TICKS(TICKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int       m_mode;
  bit [2:0] m_pend;
  int       m_pos;
  int       m_tgt;
  bit       m_up;
  bit       m_door;
  bit       m_mreq;
  int       m_left;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [2:0] floor_bit(input int f);
    bit [2:0] m;
    m = 3'b000;
    m[f-1] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_mode = M_WAIT; m_pend = 3'b000; m_pos = 1; m_tgt = 1;
    m_up = 1'b1; m_door = 1'b0; m_mreq = 1'b0; m_left = 0;
  endtask

  task automatic model_step(input bit r, input bit [2:0] b, input bit a);
    bit [2:0] here;
    bit [2:0] seen;
    int up_d, dn_d, d;
    if (r) begin
      model_reset();
      return;
    end
    here   = floor_bit(m_pos);
    m_mreq = 1'b0;
    if (m_mode == M_WAIT) begin
      seen   = m_pend;
      m_pend = m_pend | (b & ~here);
      if ((b & here) != 0) begin
        m_mode = M_DWELL; m_door = 1'b1; m_left = TICKS;
      end else begin
        up_d = 0; dn_d = 0;
        for (int f = 1; f <= 3; f++) begin
          d = f - m_pos;
          if (seen[f-1] && d > 0 && (up_d == 0 || d < up_d)) up_d = d;
          if (seen[f-1] && d < 0 && (dn_d == 0 || -d < dn_d)) dn_d = -d;
        end
        if (m_up ? (up_d == 0 && dn_d > 0) : !(dn_d == 0 && up_d > 0)) begin
          if (dn_d > 0) begin m_tgt = m_pos - dn_d; m_up = 1'b0; m_mreq = 1'b1; end
        end else if (up_d > 0) begin
          m_tgt = m_pos + up_d; m_up = 1'b1; m_mreq = 1'b1;
        end
        if (m_mreq) m_mode = M_TRAVEL;
      end
    end else if (m_mode == M_TRAVEL) begin
      m_pend = m_pend | b;
      if (a) begin
        m_pos  = m_tgt;
        m_pend = m_pend & ~floor_bit(m_tgt);
        m_door = 1'b1; m_left = TICKS; m_mode = M_DWELL;
      end
    end else begin
      m_pend = m_pend | (b & ~here);
      if ((b & here) != 0) m_left = TICKS;
      else begin
        m_left--;
        if (m_left == 0) begin m_door = 1'b0; m_mode = M_WAIT; end
      end
    end
  endtask

  task automatic check_all();
    check_val("move_req",  int'(bus.move_req),  int'(m_mreq));
    check_val("target",    int'(bus.target),    m_tgt);
    check_val("dir_up",    int'(bus.dir_up),    int'(m_up));
    check_val("door_open", int'(bus.door_open), int'(m_door));
    check_val("busy",      int'(bus.busy),      int'(m_mode != M_WAIT));
    check_val("pending",   int'(bus.pending),   int'(m_pend));
    check_val("pos",       int'(bus.pos),       m_pos);
    check_val("door_and_move", int'(bus.door_open & bus.move_req), 0);
  endtask

  task automatic step(input bit r, input bit [2:0] b, input bit a);
    rst = r; bus.call_btn = b; bus.arrived = a;
    @(posedge clk);
    model_step(r, b, a);
    #1;
    check_all();
  endtask

  // Steps with idle inputs while the door is open; returns how many more cycles it stayed open.
  task automatic dwell_out(output int highs);
    highs = 0;
    for (int k = 0; k < 40 && bus.door_open; k++) begin
      step(1'b0, 3'b000, 1'b0);
      if (bus.door_open) highs++;
    end
  endtask

  int  door_n;
  int  extra;
  int  travel;
  bit  r_in;
  bit  a_in;
  bit [2:0] b_in;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; bus.call_btn = 3'b000; bus.arrived = 1'b0;
    model_reset();
    step(1'b1, 3'b111, 1'b1);
    step(1'b1, 3'b000, 1'b0);
    check_val("reset_pos", int'(bus.pos), 1);

    // Single call to floor 3
    step(1'b0, 3'b100, 1'b0);
    check_val("r29_pending", int'(bus.pending), 4);
    step(1'b0, 3'b000, 1'b0);
    check_val("r29_move", int'(bus.move_req), 1);
    check_val("r29_tgt", int'(bus.target), 3);
    step(1'b0, 3'b000, 1'b0);
    step(1'b0, 3'b000, 1'b1);
    check_val("r29_pos", int'(bus.pos), 3);
    door_n = 1; dwell_out(extra); door_n += extra;
    check_val("r29_dwell", door_n, 4);
    check_val("r29_idle", int'(bus.busy), 0);

    // Two calls below, no second reversal
    step(1'b0, 3'b011, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    check_val("r30_tgt", int'(bus.target), 2);
    check_val("r30_dir", int'(bus.dir_up), 0);
    step(1'b0, 3'b000, 1'b1);
    dwell_out(extra);
    step(1'b0, 3'b000, 1'b0);
    check_val("r30_tgt2", int'(bus.target), 1);
    check_val("r30_dir2", int'(bus.dir_up), 0);
    step(1'b0, 3'b000, 1'b1);
    dwell_out(extra);

    // Call during travel does not retarget
    step(1'b0, 3'b100, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    step(1'b0, 3'b010, 1'b0);
    check_val("r31_hold", int'(bus.target), 3);
    step(1'b0, 3'b000, 1'b1);
    check_val("r31_pend", int'(bus.pending), 2);
    dwell_out(extra);
    step(1'b0, 3'b000, 1'b0);
    check_val("r31_tgt", int'(bus.target), 2);
    check_val("r31_dir", int'(bus.dir_up), 0);
    step(1'b0, 3'b000, 1'b1);

    // Dwell extension at floor 2
    door_n = 1;
    step(1'b0, 3'b000, 1'b0); if (bus.door_open) door_n++;
    step(1'b0, 3'b000, 1'b0); if (bus.door_open) door_n++;
    step(1'b0, 3'b010, 1'b0); if (bus.door_open) door_n++;
    dwell_out(extra); door_n += extra;
    check_val("r32_dwell", door_n, 7);
    check_val("r32_pend", int'(bus.pending), 0);

    // Reset during travel
    step(1'b0, 3'b001, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    step(1'b0, 3'b110, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    step(1'b1, 3'b000, 1'b0);
    check_val("r33_pend", int'(bus.pending), 0);
    check_val("r33_busy", int'(bus.busy), 0);
    step(1'b0, 3'b000, 1'b1);
    check_val("r33_pos", int'(bus.pos), 1);
    check_val("r33_door", int'(bus.door_open), 0);

    // Arrival and call on the target floor together
    step(1'b0, 3'b100, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    step(1'b0, 3'b100, 1'b1);
    check_val("r34_pend", int'(bus.pending), 0);
    check_val("r34_door", int'(bus.door_open), 1);
    dwell_out(extra);
    step(1'b0, 3'b000, 1'b0);
    check_val("r34_nomove", int'(bus.move_req), 0);

    // Random traffic with a simulated datapath
    travel = 0;
    for (int c = 0; c < 4000; c++) begin
      r_in = ($urandom % 300) == 0;
      b_in = (($urandom % 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      a_in = 1'b0;
      if (travel > 0) begin
        travel--;
        if (travel == 0) a_in = 1'b1;
      end else if (($urandom % 25) == 0) begin
        a_in = 1'b1;
      end
      step(r_in, b_in, a_in);
      if (r_in) travel = 0;
      if (m_mreq) travel = $urandom_range(1, 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
